uart_rx_sampler_counter: RTL

- Upstream stage of the UART RX deserializer, in the same RX clock domain.
- Counts oversampling edges within each bit and counts bits within a frame.
- Samples RX_IN around mid-bit and presents one decided bit with a one-cycle strobe.
- The deserializer consumes Sampled_bit, Bit_count and Sample_done; the RX FSM drives Enable and consumes Frame_done.

---
 rtl/uart_rx_sampler_counter.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_rx_sampler_counter.sv
// uart_rx_sampler_counter
//
// Oversampling edge/bit counter and mid-bit sampler for the UART receive path.
// Counts Edge_count within each bit and Bit_count within a frame. Samples RX_IN
// around mid-bit and presents one decided bit with a one-cycle Sample_done strobe.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   : Sampled_bit is the 2-of-3 majority of the samples at H-1, H and H+1.
//   undefined : only the sample at H is used; s0/s2 do not exist.
//
// Ports:
//   CLK         in   RX oversampling clock
//   RST         in   asynchronous active-low reset
//   RX_IN       in   serial line, already synchronised to CLK
//   Enable      in   frame active, from the RX FSM
//   PAR_EN      in   frame carries a parity bit
//   Prescale    in   oversampling ratio (8/16/32); latched while Enable=0
//   Sampled_bit out  decided bit value
//   Sample_done out  one-cycle strobe, Sampled_bit/Bit_count valid
//   Edge_count  out  edge index within the current bit
//   Bit_count   out  bit index within the frame (0 = start)
//   Frame_done  out  one-cycle pulse after the last edge of the stop bit
module uart_rx_sampler_counter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  Enable,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  Sampled_bit,
  output logic                  Sample_done,
  output logic [PRESCALE_W-1:0] Edge_count,
  output logic [4:0]            Bit_count,
  output logic                  Frame_done
);

  localparam logic [PRESCALE_W-1:0] MinPrescale = PRESCALE_W'(8);

  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] prescale_sel;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic [4:0]            last_bit;
  logic                  edge_wrap;
  logic                  frame_end;
  logic                  s1;
  logic                  vote;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic                  s0;
  logic                  s2;
`endif

  always_comb begin
    // Ratios below 8 leave no room for the H-1..H+3 sampling window.
    prescale_sel = (Prescale < MinPrescale) ? MinPrescale : Prescale;
    half         = prescale_q >> 1;
    last_edge    = prescale_q - PRESCALE_W'(1);
    last_bit     = PAR_EN ? 5'(DATA_WIDTH + 2) : 5'(DATA_WIDTH + 1);
    edge_wrap    = (Edge_count == last_edge);
    frame_end    = edge_wrap && (Bit_count == last_bit);
`ifdef UART_RX_MAJORITY_VOTE_EN
    vote = (s0 & s1) | (s0 & s2) | (s1 & s2);
`else
    vote = s1;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q  <= MinPrescale;
      Edge_count  <= '0;
      Bit_count   <= '0;
      Sampled_bit <= 1'b0;
      Sample_done <= 1'b0;
      Frame_done  <= 1'b0;
      s1          <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      s0          <= 1'b0;
      s2          <= 1'b0;
`endif
    end else begin
      Sample_done <= 1'b0;
      Frame_done  <= 1'b0;
      if (!Enable) begin
        // Idle: track Prescale, clear counters; any pending sample is dropped.
        prescale_q <= prescale_sel;
        Edge_count <= '0;
        Bit_count  <= '0;
      end else begin
        if (edge_wrap) begin
          Edge_count <= '0;
          Bit_count  <= frame_end ? 5'd0 : Bit_count + 5'd1;
          Frame_done <= frame_end;
        end else begin
          Edge_count <= Edge_count + PRESCALE_W'(1);
        end
`ifdef UART_RX_MAJORITY_VOTE_EN
        if (Edge_count == half - PRESCALE_W'(1)) s0 <= RX_IN;
        if (Edge_count == half + PRESCALE_W'(1)) s2 <= RX_IN;
`endif
        if (Edge_count == half) s1 <= RX_IN;
        // Decision one edge after the last sample; strobe is visible at H+3.
        if (Edge_count == half + PRESCALE_W'(2)) begin
          Sampled_bit <= vote;
          Sample_done <= 1'b1;
        end
      end
    end
  end

endmodule
